// File: rtl/gemm_result_streamer.sv
// gemm_result_streamer: snapshots the GEMM result matrix on idone and streams
// it element by element over valid/ready, in row-major or column-major order.
// A result that arrives while a stream is still in progress is dropped and
// recorded in the sticky ooverrun flag.
module gemm_result_streamer #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned MATRIX_WIDTH  = 4,
  parameter int unsigned MATRIX_HEIGHT = 4
) (
  input  logic                                                      iclk,
  input  logic                                                      irst,
  input  logic                                                      idone,
  input  logic [MATRIX_HEIGHT-1:0][MATRIX_WIDTH-1:0][DATA_WIDTH-1:0] iresult_matrix,
  input  logic                                                      itranspose,
  input  logic                                                      iready,
  input  logic                                                      iclr_overrun,
  output logic [DATA_WIDTH-1:0]                                     odata,
  output logic                                                      ovalid,
  output logic                                                      olast,
  output logic [((MATRIX_HEIGHT > 1) ? $clog2(MATRIX_HEIGHT) : 1)-1:0] orow,
  output logic [((MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1)-1:0]   ocol,
  output logic                                                      obusy,
  output logic                                                      ooverrun
);

  localparam int unsigned RW = (MATRIX_HEIGHT > 1) ? $clog2(MATRIX_HEIGHT) : 1;
  localparam int unsigned CW = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_e;

  state_e state_q, state_d;

  logic [MATRIX_HEIGHT-1:0][MATRIX_WIDTH-1:0][DATA_WIDTH-1:0] mat_q, mat_d;
  logic                  tr_q, tr_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic                  ovr_q, ovr_d;
  logic [DATA_WIDTH-1:0] odata_q, odata_d;
  logic                  ovalid_q, ovalid_d;
  logic                  olast_q, olast_d;
  logic                  obusy_q, obusy_d;

  logic xfer;
  logic at_last;
  logic final_xfer;
  logic capture;

  // Handshake and end-of-matrix decode shared by both comb processes
  always_comb begin
    xfer       = (state_q == STREAM) && iready;
    at_last    = (row_q == RW'(MATRIX_HEIGHT - 1)) && (col_q == CW'(MATRIX_WIDTH - 1));
    final_xfer = xfer && at_last;
    capture    = idone && ((state_q == IDLE) || final_xfer);
  end

  // FSM state register
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: a new result on the final transfer keeps us streaming
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (idone) state_d = STREAM;
      STREAM:  if (final_xfer && !idone) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the buffer, index, overrun flag and registered outputs
  always_comb begin
    mat_d = mat_q;
    tr_d  = tr_q;
    row_d = row_q;
    col_d = col_q;
    ovr_d = ovr_q;

    if (capture) begin
      mat_d = iresult_matrix;
      tr_d  = itranspose;
      row_d = '0;
      col_d = '0;
    end else if (xfer) begin
      if (at_last) begin
        row_d = '0;
        col_d = '0;
      end else if (tr_q) begin
        if (row_q == RW'(MATRIX_HEIGHT - 1)) begin
          row_d = '0;
          col_d = col_q + CW'(1);
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        if (col_q == CW'(MATRIX_WIDTH - 1)) begin
          col_d = '0;
          row_d = row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
    end

    // Set has priority over clear
    if (iclr_overrun) ovr_d = 1'b0;
    if (idone && (state_q == STREAM) && !final_xfer) ovr_d = 1'b1;

    odata_d  = mat_d[row_d][col_d];
    ovalid_d = (state_d == STREAM);
    obusy_d  = (state_d == STREAM);
    olast_d  = (state_d == STREAM) &&
               (row_d == RW'(MATRIX_HEIGHT - 1)) && (col_d == CW'(MATRIX_WIDTH - 1));
  end

  // Datapath and output registers, all cleared asynchronously
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      mat_q    <= '0;
      tr_q     <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      ovr_q    <= 1'b0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
      obusy_q  <= 1'b0;
    end else begin
      mat_q    <= mat_d;
      tr_q     <= tr_d;
      row_q    <= row_d;
      col_q    <= col_d;
      ovr_q    <= ovr_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      olast_q  <= olast_d;
      obusy_q  <= obusy_d;
    end
  end

  assign odata    = odata_q;
  assign ovalid   = ovalid_q;
  assign olast    = olast_q;
  assign orow     = row_q;
  assign ocol     = col_q;
  assign obusy    = obusy_q;
  assign ooverrun = ovr_q;

endmodule

// File: tb/tb_gemm_result_streamer.sv
// Bench for gemm_result_streamer: expected element order comes from a queue
// built by walking the source matrix in the selected order.
module tb_gemm_result_streamer;

  localparam int unsigned DW = 64;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned N  = W * H;

  typedef logic [H-1:0][W-1:0][DW-1:0] mat_t;
  typedef struct {
    logic [DW-1:0] d;
    int            r;
    int            c;
  } elem_t;

  logic          iclk;
  logic          irst;
  logic          idone;
  mat_t          iresult_matrix;
  logic          itranspose;
  logic          iready;
  logic          iclr_overrun;
  logic [DW-1:0] odata;
  logic          ovalid;
  logic          olast;
  logic [1:0]    orow;
  logic [1:0]    ocol;
  logic          obusy;
  logic          ooverrun;

  int    tests_run    = 0;
  int    tests_failed = 0;
  elem_t exp_q[$];

  gemm_result_streamer #(
    .DATA_WIDTH   (DW),
    .MATRIX_WIDTH (W),
    .MATRIX_HEIGHT(H)
  ) dut (
    .iclk          (iclk),
    .irst          (irst),
    .idone         (idone),
    .iresult_matrix(iresult_matrix),
    .itranspose    (itranspose),
    .iready        (iready),
    .iclr_overrun  (iclr_overrun),
    .odata         (odata),
    .ovalid        (ovalid),
    .olast         (olast),
    .orow          (orow),
    .ocol          (ocol),
    .obusy         (obusy),
    .ooverrun      (ooverrun)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  // kind 0: 10*i+j, kind 1: 100+10*i+j, otherwise random
  function automatic mat_t make_mat(input int kind);
    mat_t m;
    for (int i = 0; i < int'(H); i++)
      for (int j = 0; j < int'(W); j++)
        if (kind == 0)      m[i][j] = DW'(10 * i + j);
        else if (kind == 1) m[i][j] = DW'(100 + 10 * i + j);
        else                m[i][j] = {$urandom(), $urandom()};
    return m;
  endfunction

  // Reference order: walk the matrix row by row or column by column
  task automatic build_expected(input mat_t m, input logic tr);
    exp_q.delete();
    if (!tr) begin
      for (int r = 0; r < int'(H); r++)
        for (int c = 0; c < int'(W); c++) exp_q.push_back('{m[r][c], r, c});
    end else begin
      for (int c = 0; c < int'(W); c++)
        for (int r = 0; r < int'(H); r++) exp_q.push_back('{m[r][c], r, c});
    end
  endtask

  task automatic test_reset();
    irst = 1'b1; idone = 1'b0; iready = 1'b0; iclr_overrun = 1'b0;
    itranspose = 1'b0; iresult_matrix = '0;
    repeat (3) @(negedge iclk);
    irst = 1'b0;
    @(negedge iclk);
    tests_run++;
    if (ovalid !== 1'b0 || obusy !== 1'b0 || ooverrun !== 1'b0 || olast !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: valid=%b busy=%b ovr=%b last=%b, expected all 0",
               ovalid, obusy, ooverrun, olast);
    end
    tests_run++;
    if (odata !== '0 || orow !== 2'd0 || ocol !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_data: odata=%0h row=%0d col=%0d, expected 0 0 0", odata, orow, ocol);
    end
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic test_stream(input string name, input logic tr, input int kind, input int mode);
    mat_t  m;
    elem_t e;
    int    idx, cyc;
    logic  rdy;
    m = make_mat(kind);
    build_expected(m, tr);
    @(negedge iclk);
    iresult_matrix = m; itranspose = tr; idone = 1'b1; iready = 1'b0;
    tests_run++;
    if (ovalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_idle: ovalid=%b, expected 0 before capture", name, ovalid);
    end
    @(negedge iclk);
    idone = 1'b0; iresult_matrix = make_mat(2); itranspose = ~tr;
    idx = 0; cyc = 0;
    while (idx < int'(N) && cyc < 200) begin
      e = exp_q[idx];
      tests_run++;
      if (ovalid !== 1'b1 || obusy !== 1'b1 || odata !== e.d || orow !== 2'(e.r) ||
          ocol !== 2'(e.c) || olast !== (idx == int'(N) - 1)) begin
        tests_failed++;
        $display("FAIL %s_elem%0d: valid=%b busy=%b odata=%0h row=%0d col=%0d last=%b, expected 1 1 %0h %0d %0d %b",
                 name, idx, ovalid, obusy, odata, orow, ocol, olast,
                 e.d, e.r, e.c, (idx == int'(N) - 1));
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      iready = rdy;
      if (rdy) idx++;
      cyc++;
      @(negedge iclk);
    end
    iready = 1'b0;
    tests_run++;
    if (idx != int'(N)) begin
      tests_failed++;
      $display("FAIL %s_count: transfers=%0d, expected %0d within budget", name, idx, N);
    end
    tests_run++;
    if (ovalid !== 1'b0 || obusy !== 1'b0 || olast !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_end: valid=%b busy=%b last=%b, expected 0 0 0", name, ovalid, obusy, olast);
    end
  endtask

  task automatic test_overrun();
    mat_t  m;
    elem_t e;
    int    idx;
    logic  exp_ovr;
    m = make_mat(2);
    build_expected(m, 1'b0);
    exp_ovr = 1'b0;
    @(negedge iclk);
    iresult_matrix = m; itranspose = 1'b0; idone = 1'b1;
    @(negedge iclk);
    idx = 0;
    while (idx < int'(N)) begin
      e = exp_q[idx];
      tests_run++;
      if (ovalid !== 1'b1 || odata !== e.d || orow !== 2'(e.r) || ocol !== 2'(e.c) ||
          ooverrun !== exp_ovr) begin
        tests_failed++;
        $display("FAIL overrun_elem%0d: valid=%b odata=%0h row=%0d col=%0d ovr=%b, expected 1 %0h %0d %0d %b",
                 idx, ovalid, odata, orow, ocol, ooverrun, e.d, e.r, e.c, exp_ovr);
      end
      idone = 1'b0; iclr_overrun = 1'b0; iresult_matrix = make_mat(2);
      if (idx == 4) begin idone = 1'b1; exp_ovr = 1'b1; end
      if (idx == 6) begin iclr_overrun = 1'b1; exp_ovr = 1'b0; end
      if (idx == 9) begin idone = 1'b1; iclr_overrun = 1'b1; exp_ovr = 1'b1; end
      iready = 1'b1;
      idx++;
      @(negedge iclk);
    end
    idone = 1'b0; iclr_overrun = 1'b0; iready = 1'b0;
    tests_run++;
    if (ovalid !== 1'b0 || ooverrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_end: valid=%b ovr=%b, expected 0 1", ovalid, ooverrun);
    end
    iclr_overrun = 1'b1;
    @(negedge iclk);
    iclr_overrun = 1'b0;
    tests_run++;
    if (ooverrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL overrun_clear: ovr=%b, expected 0", ooverrun);
    end
  endtask

  task automatic test_back_to_back();
    mat_t  ma, mc;
    elem_t e;
    int    idx, cyc, phase;
    ma = make_mat(0);
    mc = make_mat(1);
    build_expected(ma, 1'b0);
    @(negedge iclk);
    iresult_matrix = ma; itranspose = 1'b0; idone = 1'b1;
    @(negedge iclk);
    idx = 0; cyc = 0; phase = 0;
    while (!(phase == 1 && idx == int'(N)) && cyc < 100) begin
      e = exp_q[idx];
      tests_run++;
      if (ovalid !== 1'b1 || odata !== e.d || orow !== 2'(e.r) || ocol !== 2'(e.c) ||
          olast !== (idx == int'(N) - 1) || ooverrun !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_p%0d_elem%0d: valid=%b odata=%0h row=%0d col=%0d last=%b ovr=%b, expected 1 %0h %0d %0d %b 0",
                 phase, idx, ovalid, odata, orow, ocol, olast, ooverrun,
                 e.d, e.r, e.c, (idx == int'(N) - 1));
      end
      idone = 1'b0; iresult_matrix = make_mat(2); itranspose = 1'b0;
      iready = 1'b1;
      if (phase == 0 && idx == int'(N) - 1) begin
        idone = 1'b1; iresult_matrix = mc; itranspose = 1'b1;
        build_expected(mc, 1'b1);
        idx = 0; phase = 1;
      end else begin
        idx++;
      end
      cyc++;
      @(negedge iclk);
    end
    idone = 1'b0; iready = 1'b0;
    tests_run++;
    if (phase != 1 || idx != int'(N) || ovalid !== 1'b0 || ooverrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_end: phase=%0d idx=%0d valid=%b ovr=%b, expected 1 %0d 0 0",
               phase, idx, ovalid, ooverrun, N);
    end
  endtask

  task automatic test_reset_mid();
    mat_t m;
    int   idx;
    m = make_mat(0);
    build_expected(m, 1'b0);
    @(negedge iclk);
    iresult_matrix = m; itranspose = 1'b0; idone = 1'b1;
    @(negedge iclk);
    idone = 1'b0;
    idx = 0;
    while (idx < 7) begin
      iready = 1'b1;
      idx++;
      @(negedge iclk);
    end
    iready = 1'b0;
    tests_run++;
    if (ovalid !== 1'b1 || odata !== exp_q[7].d) begin
      tests_failed++;
      $display("FAIL rstmid_pre: valid=%b odata=%0h, expected 1 %0h", ovalid, odata, exp_q[7].d);
    end
    irst = 1'b1;
    #1;
    tests_run++;
    if (ovalid !== 1'b0 || obusy !== 1'b0 || odata !== '0 || orow !== 2'd0 || ocol !== 2'd0) begin
      tests_failed++;
      $display("FAIL rstmid_async: valid=%b busy=%b odata=%0h row=%0d col=%0d, expected 0 0 0 0 0",
               ovalid, obusy, odata, orow, ocol);
    end
    #1;
    irst = 1'b0;
    @(negedge iclk);
    tests_run++;
    if (ovalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_idle: valid=%b, expected 0", ovalid);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream("row_major", 1'b0, 0, 0);
    test_stream("col_major", 1'b1, 0, 0);
    test_stream("stall_toggle", 1'b0, 0, 1);
    test_stream("stall_toggle_col", 1'b1, 2, 1);
    test_stream("random_row", 1'b0, 2, 2);
    test_stream("random_col", 1'b1, 2, 2);
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_stream("after_reset", 1'b0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
